// File: rtl/lcd_pkg.sv
// Shared constants, enums and small helpers for the note-grid LCD controller.
// HD44780-style command set, glyph codes and DDRAM row bases live here.
package lcd_pkg;

    localparam logic [7:0] CmdFuncSet   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CmdDispOn    = 8'h0C;
    localparam logic [7:0] CmdEntryMode = 8'h06;
    localparam logic [7:0] CmdClear     = 8'h01;
    localparam logic [7:0] CmdSetDdram  = 8'h80;

    localparam logic [7:0] GlyphRest = 8'h20;
    localparam logic [7:0] GlyphNote = 8'h4F;
    localparam logic [7:0] GlyphTie  = 8'h3C;

    typedef enum logic [2:0] {
        StPwrWait,
        StInit,
        StIdle,
        StRowAddr,
        StChar,
        StDone
    } top_state_e;

    typedef enum logic [1:0] {
        PhIdle,
        PhSetup,
        PhHigh,
        PhWait
    } bus_phase_e;

    function automatic logic [7:0] row_base(input logic [1:0] row);
        logic [7:0] base;
        unique case (row)
            2'd0: base = 8'h00;
            2'd1: base = 8'h40;
            2'd2: base = 8'h14;
            2'd3: base = 8'h54;
        endcase
        return base;
    endfunction

    function automatic logic [7:0] glyph(input logic [1:0] note, input logic [7:0] hold);
        logic [7:0] code;
        unique case (note)
            2'd0: code = GlyphRest;
            2'd1: code = GlyphNote;
            2'd2: code = GlyphTie;
            2'd3: code = hold;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// One LCD bus write: SETUP -> E high -> execution wait, timed by a cycle counter.
// Owns LCD_E/RS/DATA; RS and DATA are latched on start and held until the wait ends.
module lcd_bus_xfer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned E_HIGH_CYC = 25,
    parameter int unsigned EXEC_CYC   = 2500,
    parameter int unsigned CLEAR_CYC  = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] data_i,
    output logic       done_o,
    output logic       lcd_e_o,
    output logic       lcd_rs_o,
    output logic [7:0] lcd_data_o
);

    localparam int unsigned MaxA   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int unsigned MaxB   = (EXEC_CYC > CLEAR_CYC) ? EXEC_CYC : CLEAR_CYC;
    localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    bus_phase_e      phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            e_q, e_d;
    logic [CntW-1:0] wait_last;

    // Clear needs the long execution time; everything else uses the normal one.
    always_comb begin
        wait_last = CntW'(EXEC_CYC - 1);
        if (!rs_q && data_q == CmdClear) begin
            wait_last = CntW'(CLEAR_CYC - 1);
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        done_o  = 1'b0;
        unique case (phase_q)
            PhIdle: begin
                if (start_i) begin
                    phase_d = PhSetup;
                    cnt_d   = '0;
                    rs_d    = rs_i;
                    data_d  = data_i;
                end
            end
            PhSetup: begin
                if (cnt_q == CntW'(SETUP_CYC - 1)) begin
                    phase_d = PhHigh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PhHigh: begin
                if (cnt_q == CntW'(E_HIGH_CYC - 1)) begin
                    phase_d = PhWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PhWait: begin
                if (cnt_q == wait_last) begin
                    phase_d = PhIdle;
                    cnt_d   = '0;
                    done_o  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: phase_d = PhIdle;
        endcase
        e_d = (phase_d == PhHigh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PhIdle;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            e_q     <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            e_q     <= e_d;
        end
    end

    assign lcd_e_o    = e_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;

endmodule

// File: rtl/note_lcd_ctrl.sv
// Renders a 2-bit-per-cell note grid onto a character LCD: power-up wait, init,
// then one row-address command plus COLS characters per row for each changed frame.
module note_lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned COLS        = 16,
    parameter int unsigned ROWS        = 2,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned E_HIGH_CYC  = 25,
    parameter int unsigned EXEC_CYC    = 2500,
    parameter int unsigned CLEAR_CYC   = 100000,
    parameter int unsigned POWERUP_CYC = 1000000,
    parameter logic [7:0]  HOLD_GLYPH  = 8'hDB
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] note_bit0,
    input  logic [ROWS*COLS-1:0] note_bit1,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_skipped,
    output logic                 LCD_E,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    output logic [7:0]           LCD_DATA,
    output logic                 LCD_ON
);

    localparam int unsigned Cells = ROWS * COLS;
    localparam int unsigned ColW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CellW = (Cells > 1) ? $clog2(Cells) : 1;
    localparam int unsigned PwrW  = (POWERUP_CYC > 1) ? $clog2(POWERUP_CYC) : 1;

    top_state_e       state_q, state_d;
    logic [PwrW-1:0]  pwr_cnt_q, pwr_cnt_d;
    logic [1:0]       init_idx_q, init_idx_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [ColW-1:0]  col_q, col_d;
    logic             pend_q, pend_d;
    logic             skip_q, skip_d;
    logic [Cells-1:0] shadow0_q, shadow0_d, shadow1_q, shadow1_d;
    logic [Cells-1:0] disp0_q, disp0_d, disp1_q, disp1_d;
    logic             disp_valid_q, disp_valid_d;

    logic             xfer_start, xfer_rs, xfer_done, xfer_state, step;
    logic [7:0]       xfer_data, init_cmd;
    logic [CellW-1:0] cell_idx;
    logic [1:0]       cell_note;
    logic             same_frame;

    always_comb begin
        cell_idx  = CellW'(row_q) * CellW'(COLS) + CellW'(col_q);
        cell_note = {shadow1_q[cell_idx], shadow0_q[cell_idx]};
        unique case (init_idx_q)
            2'd0: init_cmd = CmdFuncSet;
            2'd1: init_cmd = CmdDispOn;
            2'd2: init_cmd = CmdEntryMode;
            2'd3: init_cmd = CmdClear;
        endcase
        same_frame = disp_valid_q && (note_bit0 == disp0_q) && (note_bit1 == disp1_q);
        // One start pulse per transfer; step marks the cycle the bus reports completion.
        xfer_state = (state_q == StInit) || (state_q == StRowAddr) || (state_q == StChar);
        xfer_start = xfer_state && !pend_q;
        step       = pend_q && xfer_done;
    end

    always_comb begin
        state_d      = state_q;
        pwr_cnt_d    = pwr_cnt_q;
        init_idx_d   = init_idx_q;
        row_d        = row_q;
        col_d        = col_q;
        pend_d       = pend_q;
        skip_d       = skip_q;
        shadow0_d    = shadow0_q;
        shadow1_d    = shadow1_q;
        disp0_d      = disp0_q;
        disp1_d      = disp1_q;
        disp_valid_d = disp_valid_q;
        xfer_rs      = 1'b0;
        xfer_data    = 8'h00;

        if (xfer_start) begin
            pend_d = 1'b1;
        end else if (step) begin
            pend_d = 1'b0;
        end

        unique case (state_q)
            StPwrWait: begin
                if (pwr_cnt_q == PwrW'(POWERUP_CYC - 1)) begin
                    pwr_cnt_d = '0;
                    state_d   = StInit;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            StInit: begin
                xfer_data = init_cmd;
                if (step) begin
                    if (init_idx_q == 2'd3) begin
                        init_idx_d = 2'd0;
                        state_d    = StIdle;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                    end
                end
            end
            StIdle: begin
                if (frame_valid) begin
                    shadow0_d = note_bit0;
                    shadow1_d = note_bit1;
                    row_d     = '0;
                    col_d     = '0;
                    skip_d    = same_frame;
                    state_d   = same_frame ? StDone : StRowAddr;
                end
            end
            StRowAddr: begin
                xfer_data = CmdSetDdram | row_base(2'(row_q));
                if (step) begin
                    state_d = StChar;
                end
            end
            StChar: begin
                xfer_rs   = 1'b1;
                xfer_data = glyph(cell_note, HOLD_GLYPH);
                if (step) begin
                    if (col_q == ColW'(COLS - 1)) begin
                        col_d = '0;
                        if (row_q == RowW'(ROWS - 1)) begin
                            row_d   = '0;
                            state_d = StDone;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = StRowAddr;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StDone: begin
                disp0_d      = shadow0_q;
                disp1_d      = shadow1_q;
                disp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StPwrWait;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StPwrWait;
            pwr_cnt_q    <= '0;
            init_idx_q   <= 2'd0;
            row_q        <= '0;
            col_q        <= '0;
            pend_q       <= 1'b0;
            skip_q       <= 1'b0;
            shadow0_q    <= '0;
            shadow1_q    <= '0;
            disp0_q      <= '0;
            disp1_q      <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwr_cnt_q    <= pwr_cnt_d;
            init_idx_q   <= init_idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pend_q       <= pend_d;
            skip_q       <= skip_d;
            shadow0_q    <= shadow0_d;
            shadow1_q    <= shadow1_d;
            disp0_q      <= disp0_d;
            disp1_q      <= disp1_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    lcd_bus_xfer #(
        .SETUP_CYC  (SETUP_CYC),
        .E_HIGH_CYC (E_HIGH_CYC),
        .EXEC_CYC   (EXEC_CYC),
        .CLEAR_CYC  (CLEAR_CYC)
    ) u_bus (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (xfer_start),
        .rs_i       (xfer_rs),
        .data_i     (xfer_data),
        .done_o     (xfer_done),
        .lcd_e_o    (LCD_E),
        .lcd_rs_o   (LCD_RS),
        .lcd_data_o (LCD_DATA)
    );

    assign frame_ready   = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign frame_done    = (state_q == StDone);
    assign frame_skipped = (state_q == StDone) && skip_q;
    assign LCD_RW        = 1'b0;
    assign LCD_ON        = 1'b1;

endmodule
